// File: rtl/sram_prog_loader.sv
// sram_prog_loader
//
// Loads a block of instruction bytes into the on-chip instruction SRAM.
// Software pushes bytes into a small FIFO and then issues one start command.
// For each word the block writes the SRAM address, then the data, then fires
// LOAD_ON and LOAD_OFF control writes. It then waits out the serial shift
// before it moves on to the next word.
//
// Ports:
//   csi_clk, rsi_reset         clock, asynchronous active-high reset
//   avs_prog_write/writedata   byte push into the FIFO (bits [7:0])
//   avs_ldctrl_write/writedata command: [8:0] base, [24:16] count,
//                              [25] TEST, [30] abort, [31] start
//   avs_ldstat_readdata        status: [0] busy, [1] done, [3] overflow,
//                              [8:4] FIFO level, [24:16] current address
//   avm_sram_addr_*            address write port of the SRAM shell
//   avm_sram_data_*            data write port of the SRAM shell
//   avm_cpuctrl_*              control write port of the SRAM shell
module sram_prog_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int SHIFT_WAIT = 19
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic [31:0] avs_prog_writedata,
  input  logic        avs_prog_write,
  input  logic [31:0] avs_ldctrl_writedata,
  input  logic        avs_ldctrl_write,
  output logic [31:0] avs_ldstat_readdata,
  output logic [31:0] avm_sram_addr_writedata,
  output logic        avm_sram_addr_write,
  output logic [31:0] avm_sram_data_writedata,
  output logic        avm_sram_data_write,
  output logic [31:0] avm_cpuctrl_writedata,
  output logic        avm_cpuctrl_write
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SC_W  = $clog2(SHIFT_WAIT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_WR_ADDR   = 3'd2;
  localparam logic [2:0] S_WR_DATA   = 3'd3;
  localparam logic [2:0] S_LOAD_ON   = 3'd4;
  localparam logic [2:0] S_LOAD_OFF  = 3'd5;
  localparam logic [2:0] S_SHIFT     = 3'd6;
  localparam logic [2:0] S_NEXT      = 3'd7;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  test_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  rst_bit_q;
  logic [SC_W-1:0]       shift_cnt;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH-1:0] head_byte;

  logic                  cmd_abort;
  logic                  cmd_start;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_count;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  push_ok;
  logic                  unused_bits;

  // Abort beats start. A start is only honoured while idle.
  assign cmd_abort = avs_ldctrl_write & avs_ldctrl_writedata[30];
  assign cmd_start = avs_ldctrl_write & avs_ldctrl_writedata[31] &
                     ~avs_ldctrl_writedata[30] & (state == S_IDLE);
  assign cmd_addr  = avs_ldctrl_writedata[ADDR_WIDTH-1:0];
  assign cmd_count = avs_ldctrl_writedata[16 +: ADDR_WIDTH];

  assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_pop  = (state == S_WR_DATA) && (level != '0);
  // A push into a full FIFO still fits if the head leaves in the same cycle.
  assign push_ok   = avs_prog_write & ~cmd_abort & (~fifo_full | fifo_pop);

  // FIFO pointers, level and the sticky overflow flag.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else if (cmd_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, fifo_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (avs_prog_write && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (cmd_start)
        ovf_q <= 1'b0;
    end
  end

  // Storage only. Stale contents are harmless because the head is masked when empty.
  always_ff @(posedge csi_clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= avs_prog_writedata[DATA_WIDTH-1:0];
  end

  // Sequencer. Each state lasts one cycle, except WAIT_DATA and SHIFT.
  // rst_bit_q keeps the shell's RST bit low only while this block is in reset.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      test_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_cnt <= '0;
      rst_bit_q <= 1'b0;
    end else begin
      rst_bit_q <= 1'b1;
      if (cmd_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start) begin
              if (cmd_count != '0) begin
                addr_q  <= cmd_addr;
                count_q <= cmd_count;
                test_q  <= avs_ldctrl_writedata[25];
                done_q  <= 1'b0;
                state   <= S_WAIT_DATA;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_WAIT_DATA: if (level != '0) state <= S_WR_ADDR;
          S_WR_ADDR:   state <= S_WR_DATA;
          S_WR_DATA:   state <= S_LOAD_ON;
          S_LOAD_ON:   state <= S_LOAD_OFF;
          S_LOAD_OFF: begin
            shift_cnt <= '0;
            state     <= S_SHIFT;
          end
          S_SHIFT: begin
            if (shift_cnt == SC_W'(SHIFT_WAIT - 1))
              state <= S_NEXT;
            else
              shift_cnt <= shift_cnt + SC_W'(1);
          end
          S_NEXT: begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            count_q <= count_q - ADDR_WIDTH'(1);
            if (count_q == ADDR_WIDTH'(1)) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= S_WAIT_DATA;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign head_byte = (level != '0) ? fifo_mem[rd_ptr] : '0;

  assign avm_sram_addr_write     = (state == S_WR_ADDR);
  assign avm_sram_data_write     = (state == S_WR_DATA);
  assign avm_cpuctrl_write       = (state == S_LOAD_ON) || (state == S_LOAD_OFF);
  assign avm_sram_addr_writedata = {{(32-ADDR_WIDTH){1'b0}}, addr_q};
  assign avm_sram_data_writedata = {{(32-DATA_WIDTH){1'b0}}, head_byte};
  assign avm_cpuctrl_writedata   = {25'b0, test_q, 1'b0, rst_bit_q, 2'b00,
                                    (state == S_LOAD_ON), 1'b0};

  always_comb begin
    avs_ldstat_readdata                  = '0;
    avs_ldstat_readdata[0]               = (state != S_IDLE);
    avs_ldstat_readdata[1]               = done_q;
    avs_ldstat_readdata[3]               = ovf_q;
    avs_ldstat_readdata[4 +: LVL_W]      = level;
    avs_ldstat_readdata[16 +: ADDR_WIDTH] = addr_q;
  end

  assign unused_bits = ^{avs_prog_writedata[31:DATA_WIDTH],
                         avs_ldctrl_writedata[29:26],
                         avs_ldctrl_writedata[15:ADDR_WIDTH]};

endmodule

// File: tb/tb_sram_prog_loader.sv
// tb_sram_prog_loader
//
// Bench for sram_prog_loader. A reference model holds the FIFO contents and
// the status flags. Each start command queues the strobe sequence that the
// SRAM shell should see. A monitor on the falling edge pops that queue and
// compares it against every strobe the loader drives. Data bytes are taken
// from the model FIFO in push order.
module tb_sram_prog_loader;

  logic        csi_clk = 1'b0;
  logic        rsi_reset;
  logic [31:0] avs_prog_writedata;
  logic        avs_prog_write;
  logic [31:0] avs_ldctrl_writedata;
  logic        avs_ldctrl_write;
  logic [31:0] avs_ldstat_readdata;
  logic [31:0] avm_sram_addr_writedata;
  logic        avm_sram_addr_write;
  logic [31:0] avm_sram_data_writedata;
  logic        avm_sram_data_write;
  logic [31:0] avm_cpuctrl_writedata;
  logic        avm_cpuctrl_write;

  localparam int K_ADDR = 1;
  localparam int K_DATA = 2;
  localparam int K_CTRL = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic       model_done;
  logic       model_ovf;
  logic [8:0] model_addr;
  int         addr_cyc[$];
  int         data_cyc[$];
  int         ctrl_cyc[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  sram_prog_loader dut (
    .csi_clk                 (csi_clk),
    .rsi_reset               (rsi_reset),
    .avs_prog_writedata      (avs_prog_writedata),
    .avs_prog_write          (avs_prog_write),
    .avs_ldctrl_writedata    (avs_ldctrl_writedata),
    .avs_ldctrl_write        (avs_ldctrl_write),
    .avs_ldstat_readdata     (avs_ldstat_readdata),
    .avm_sram_addr_writedata (avm_sram_addr_writedata),
    .avm_sram_addr_write     (avm_sram_addr_write),
    .avm_sram_data_writedata (avm_sram_data_writedata),
    .avm_sram_data_write     (avm_sram_data_write),
    .avm_cpuctrl_writedata   (avm_cpuctrl_writedata),
    .avm_cpuctrl_write       (avm_cpuctrl_write)
  );

  always #5 csi_clk = ~csi_clk;

  always @(posedge csi_clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
  endtask

  function automatic logic [31:0] expStatus(input logic busy);
    logic [31:0] s;
    s        = '0;
    s[0]     = busy;
    s[1]     = model_done;
    s[3]     = model_ovf;
    s[8:4]   = 5'(model_q.size());
    s[24:16] = model_addr;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge csi_clk);
    #1;
  endtask

  task automatic tickUntil(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic resetModel();
    exp_q.delete();
    model_q.delete();
    model_done = 1'b0;
    model_ovf  = 1'b0;
    model_addr = '0;
  endtask

  // One byte push. The model is updated after the edge. This way, a pop that
  // the monitor sees in the same cycle has already freed its slot.
  task automatic pushByte(input logic [7:0] b, output int pc);
    avs_prog_writedata = {$urandom() % 32'h0100_0000, b} ;
    avs_prog_writedata[7:0] = b;
    avs_prog_write = 1'b1;
    pc = cyc;
    tick(1);
    avs_prog_write = 1'b0;
    if (model_q.size() < 16) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  // Start command. The strobe sequence for every word is queued up front.
  task automatic applyStimulus(input logic [8:0] base, input logic [8:0] count,
                               input logic test, output int s);
    logic [31:0] w;
    w        = $urandom();
    w[8:0]   = base;
    w[24:16] = count;
    w[25]    = test;
    w[30]    = 1'b0;
    w[31]    = 1'b1;
    avs_ldctrl_writedata = w;
    avs_ldctrl_write     = 1'b1;
    s = cyc;
    tick(1);
    avs_ldctrl_write     = 1'b0;
    avs_ldctrl_writedata = $urandom();
    model_ovf = 1'b0;
    if (count != 0) begin
      model_done = 1'b0;
      for (int i = 0; i < int'(count); i++) begin
        exp_q.push_back('{K_ADDR, 32'((int'(base) + i) % 512)});
        exp_q.push_back('{K_DATA, 32'h0});
        exp_q.push_back('{K_CTRL, 32'h12 | (32'(test) << 6)});
        exp_q.push_back('{K_CTRL, 32'h10 | (32'(test) << 6)});
      end
      model_addr = 9'((int'(base) + int'(count)) % 512);
    end else begin
      model_done = 1'b1;
    end
  endtask

  task automatic waitDone(input int bound);
    int k;
    k = 0;
    while (!(avs_ldstat_readdata[1] && !avs_ldstat_readdata[0]) && k < bound) begin
      tick(1);
      k++;
    end
    checkOutput("done_within_bound", 32'(k < bound), 32'd1);
    if (k < bound) model_done = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge csi_clk) begin
    int          ns;
    exp_t        e;
    logic [31:0] act;
    if (!rsi_reset) begin
      ns = int'(avm_sram_addr_write) + int'(avm_sram_data_write) +
           int'(avm_cpuctrl_write);
      if (ns > 1) begin
        checkOutput("single_strobe", 32'(ns), 32'd1);
      end else if (ns == 1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe",
                      {29'b0, avm_sram_addr_write, avm_sram_data_write,
                       avm_cpuctrl_write}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (avm_sram_addr_write) begin
            addr_cyc.push_back(cyc);
            checkOutput("strobe_kind", K_ADDR, e.kind);
            checkOutput("addr_value", avm_sram_addr_writedata, e.val);
          end else if (avm_sram_data_write) begin
            data_cyc.push_back(cyc);
            checkOutput("strobe_kind", K_DATA, e.kind);
            if (model_q.size() == 0) begin
              checkOutput("model_has_byte", 32'(model_q.size()), 32'd1);
            end else begin
              act = {24'b0, model_q.pop_front()};
              checkOutput("data_value", avm_sram_data_writedata, act);
            end
          end else begin
            ctrl_cyc.push_back(cyc);
            checkOutput("strobe_kind", K_CTRL, e.kind);
            checkOutput("cpuctrl_value", avm_cpuctrl_writedata, e.val);
          end
        end
      end
    end
  end

  initial begin
    int s, p1, p2, a, n;
    logic [8:0] base;
    logic [31:0] w;

    rsi_reset = 1'b1;
    avs_prog_write = 1'b0;
    avs_prog_writedata = '0;
    avs_ldctrl_write = 1'b0;
    avs_ldctrl_writedata = '0;
    resetModel();
    tick(3);
    checkOutput("reset_status", avs_ldstat_readdata, 32'd0);
    checkOutput("reset_strobes", {29'b0, avm_sram_addr_write,
                avm_sram_data_write, avm_cpuctrl_write}, 32'd0);
    checkOutput("reset_cpuctrl_wd", avm_cpuctrl_writedata, 32'd0);
    rsi_reset = 1'b0;
    tick(2);
    checkOutput("post_reset_status", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] single word");
    addr_cyc.delete(); data_cyc.delete(); ctrl_cyc.delete();
    pushByte(8'hA5, p1);
    applyStimulus(9'h010, 9'd1, 1'b0, s);
    tickUntil(s + 25);
    checkOutput("single_busy_c25", {30'b0, avs_ldstat_readdata[1:0]}, 32'd1);
    tick(1);
    model_done = 1'b1;
    checkOutput("single_status_c26", avs_ldstat_readdata, expStatus(1'b0));
    checkOutput("single_addr_cycle", 32'(addr_cyc[0]), 32'(s + 2));
    checkOutput("single_data_cycle", 32'(data_cyc[0]), 32'(s + 3));
    checkOutput("single_ldon_cycle", 32'(ctrl_cyc[0]), 32'(s + 4));
    checkOutput("single_ldoff_cycle", 32'(ctrl_cyc[1]), 32'(s + 5));

    $display("[TB] burst with wrap");
    addr_cyc.delete();
    for (int i = 0; i < 3; i++) pushByte(8'($urandom()), p1);
    applyStimulus(9'h1FF, 9'd3, 1'b1, s);
    waitDone(120);
    checkOutput("burst_addr_count", 32'(addr_cyc.size()), 32'd3);
    checkOutput("burst_gap0", 32'(addr_cyc[1] - addr_cyc[0]), 32'd25);
    checkOutput("burst_gap1", 32'(addr_cyc[2] - addr_cyc[1]), 32'd25);
    checkOutput("burst_status", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] underflow stall");
    addr_cyc.delete();
    applyStimulus(9'($urandom()), 9'd2, 1'($urandom()), s);
    tick(10);
    pushByte(8'($urandom()), p1);
    tick(40);
    pushByte(8'($urandom()), p2);
    waitDone(120);
    checkOutput("stall_addr0_cycle", 32'(addr_cyc[0]), 32'(p1 + 2));
    checkOutput("stall_addr1_cycle", 32'(addr_cyc[1]), 32'(p2 + 2));
    checkOutput("stall_status", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] overflow");
    for (int i = 0; i < 17; i++) pushByte(8'($urandom()), p1);
    checkOutput("ovf_status", avs_ldstat_readdata, expStatus(1'b0));
    applyStimulus(9'($urandom()), 9'd1, 1'b0, s);
    tick(2);
    pushByte(8'($urandom()), p1);
    waitDone(60);
    checkOutput("full_pushpop_status", avs_ldstat_readdata, expStatus(1'b0));
    applyStimulus(9'($urandom()), 9'd16, 1'($urandom()), s);
    waitDone(450);
    checkOutput("drain_status", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] abort mid-shift");
    for (int i = 0; i < 5; i++) pushByte(8'($urandom()), p1);
    base = 9'($urandom());
    applyStimulus(base, 9'd5, 1'b0, s);
    tick(8);
    w        = $urandom();
    w[30]    = 1'b1;
    w[24:16] = 9'd7;
    avs_ldctrl_writedata = w;
    avs_ldctrl_write     = 1'b1;
    avs_prog_writedata   = $urandom();
    avs_prog_write       = 1'b1;
    tick(1);
    avs_ldctrl_write = 1'b0;
    avs_prog_write   = 1'b0;
    exp_q.delete();
    model_q.delete();
    model_addr = base;
    checkOutput("abort_no_strobe", {29'b0, avm_sram_addr_write,
                avm_sram_data_write, avm_cpuctrl_write}, 32'd0);
    checkOutput("abort_status", avs_ldstat_readdata, expStatus(1'b0));
    tick(5);
    applyStimulus(9'($urandom()), 9'd0, 1'b0, s);
    checkOutput("zero_count_done", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 2; i++) pushByte(8'($urandom()), p1);
    applyStimulus(9'($urandom()), 9'd2, 1'b1, s);
    tick(2);
    checkOutput("in_wr_data", 32'(avm_sram_data_write), 32'd1);
    #2 rsi_reset = 1'b1;
    resetModel();
    #1;
    checkOutput("arst_strobes", {29'b0, avm_sram_addr_write,
                avm_sram_data_write, avm_cpuctrl_write}, 32'd0);
    checkOutput("arst_addr_wd", avm_sram_addr_writedata, 32'd0);
    checkOutput("arst_data_wd", avm_sram_data_writedata, 32'd0);
    checkOutput("arst_cpuctrl_wd", avm_cpuctrl_writedata, 32'd0);
    checkOutput("arst_status", avs_ldstat_readdata, 32'd0);
    tick(1);
    rsi_reset = 1'b0;
    tick(30);
    checkOutput("arst_after_release", avs_ldstat_readdata, expStatus(1'b0));

    $display("[TB] random bursts");
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 4);
      addr_cyc.delete();
      for (int i = 0; i < n; i++) pushByte(8'($urandom()), p1);
      a = $urandom_range(0, 511);
      applyStimulus(9'(a), 9'(n), 1'($urandom()), s);
      waitDone(n * 25 + 20);
      checkOutput("rand_first_addr_cycle", 32'(addr_cyc[0]), 32'(s + 2));
      checkOutput("rand_status", avs_ldstat_readdata, expStatus(1'b0));
    end

    tick(3);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
